// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request controller.
//   NUM_FLOORS : number of floors served (indices 0..NUM_FLOORS-1)
//   floor_t    : floor index type
//   UP / DOWN  : car direction encoding on UD_Answer / UD_Request
//   state_e    : request-controller FSM states
package elevator_pkg;

   localparam int NUM_FLOORS = 4;
   localparam int FLOOR_W    = 2;

   typedef logic [FLOOR_W-1:0] floor_t;

   localparam logic UP   = 1'b1;
   localparam logic DOWN = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EVAL,
      ST_DOOR,
      ST_FRSVC
   } state_e;

endpackage

// File: rtl/call_latch.sv
// Call latch: holds the car-panel and hall call bits until serviced.
//   clk, reset            : clock, asynchronous active-high reset
//   cab_btn [N-1:0]       : car-panel pulses, bit n = floor n
//   hall_up [N-2:0]       : up hall pulses, bit n = floor n
//   hall_dn [N-2:0]       : down hall pulses, bit n = floor n+1
//   at_floor              : floor the car is at
//   clear_at              : drop every call at at_floor (service taken)
//   absorb_at             : door open at at_floor, presses there are not kept
//   cab_q/up_q/dn_q       : latched call bits, same bit layout as the buttons
//   pending [N-1:0]       : per-floor OR of all latched calls
module call_latch
   import elevator_pkg::*;
#(
   parameter int N = elevator_pkg::NUM_FLOORS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] cab_btn,
   input  logic [N-2:0] hall_up,
   input  logic [N-2:0] hall_dn,
   input  floor_t       at_floor,
   input  logic         clear_at,
   input  logic         absorb_at,
   output logic [N-1:0] cab_q,
   output logic [N-2:0] up_q,
   output logic [N-2:0] dn_q,
   output logic [N-1:0] pending
);

   logic [N-1:0] cab_d;
   logic [N-2:0] up_d;
   logic [N-2:0] dn_d;
   logic [N-1:0] kill_mask;

   // Clearing and absorbing both mean "nothing may remain at this floor";
   // the kill mask beats a same-cycle press there, presses elsewhere still set.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      kill_mask = '0;
      if (clear_at || absorb_at) begin
         kill_mask = {{(N-1){1'b0}}, 1'b1} << at_floor;
      end
      cab_d = (cab_q | cab_btn) & ~kill_mask;
      up_d  = (up_q  | hall_up) & ~kill_mask[N-2:0];
      dn_d  = (dn_q  | hall_dn) & ~kill_mask[N-1:1];
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cab_q <= '0;
         up_q  <= '0;
         dn_q  <= '0;
      end else begin
         cab_q <= cab_d;
         up_q  <= up_d;
         dn_q  <= dn_d;
      end
   end

   // Up calls exist for floors 0..N-2, down calls for floors 1..N-1.
   assign pending = cab_q | {1'b0, up_q} | {dn_q, 1'b0};

endmodule

// File: rtl/request_controller.sv
// Elevator request controller: latches calls, decides whether the car stops
// on arrival, holds the door, and publishes the next target floor.
//   clk, reset        : clock, asynchronous active-high reset
//   cab_btn           : car-panel call pulses, bit n = floor n
//   hall_up / hall_dn : hall call pulses (up: floor n, down: floor n+1)
//   Delay / DoneDelay       : arrival notice and its one-clock acknowledge
//   FR_Delay / DoneFRDelay  : floor-request poll and its one-clock acknowledge
//   Actual_Stage, UD_Answer, STOP : car floor, direction (1 = up), idle flag
//   next_stage        : {valid, floor} of the next target, 3'b000 = none
//   OC_Request        : door-open request, high DOOR_HOLD clocks per service
//   UD_Request        : 1 when the target lies above Actual_Stage
//   NO_STOP           : wake request for an idle car with work pending
//   pending           : per-floor call lamps
module request_controller #(
   parameter int DOOR_HOLD  = 8,
   parameter int NUM_FLOORS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] cab_btn,
   input  logic [NUM_FLOORS-2:0] hall_up,
   input  logic [NUM_FLOORS-2:0] hall_dn,
   input  logic                  Delay,
   input  logic                  FR_Delay,
   input  logic [1:0]            Actual_Stage,
   input  logic                  UD_Answer,
   input  logic                  STOP,
   output logic [2:0]            next_stage,
   output logic                  OC_Request,
   output logic                  UD_Request,
   output logic                  NO_STOP,
   output logic                  DoneDelay,
   output logic                  DoneFRDelay,
   output logic [NUM_FLOORS-1:0] pending
);

   import elevator_pkg::*;

   localparam int CNT_W = $clog2(DOOR_HOLD + 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    fr_ack_q, fr_ack_d;
   logic [2:0]              next_stage_q, next_stage_d;
   logic                    ud_q, ud_d;
   logic                    no_stop_q, no_stop_d;

   logic [NUM_FLOORS-1:0]   cab_call;
   logic [NUM_FLOORS-2:0]   up_call;
   logic [NUM_FLOORS-2:0]   dn_call;
   logic [NUM_FLOORS-1:0]   pending_w;
   logic [NUM_FLOORS-1:0]   up_by_floor;
   logic [NUM_FLOORS-1:0]   dn_by_floor;
   logic [NUM_FLOORS-1:0]   up_btn_by_floor;
   logic [NUM_FLOORS-1:0]   dn_btn_by_floor;
   logic                    clear_at;
   logic                    absorb_at;
   logic                    press_here;
   logic                    hall_here;
   logic                    above_found, below_found;
   floor_t                  above_floor, below_floor;
   logic                    tgt_valid;
   floor_t                  tgt_floor;
   logic                    stop_here;

   call_latch #(
      .N(NUM_FLOORS)
   ) u_call_latch (
      .clk      (clk),
      .reset    (reset),
      .cab_btn  (cab_btn),
      .hall_up  (hall_up),
      .hall_dn  (hall_dn),
      .at_floor (Actual_Stage),
      .clear_at (clear_at),
      .absorb_at(absorb_at),
      .cab_q    (cab_call),
      .up_q     (up_call),
      .dn_q     (dn_call),
      .pending  (pending_w)
   );

   // Re-index hall calls and buttons by floor so they can be picked with Actual_Stage.
   assign up_by_floor     = {1'b0, up_call};
   assign dn_by_floor     = {dn_call, 1'b0};
   assign up_btn_by_floor = {1'b0, hall_up};
   assign dn_btn_by_floor = {hall_dn, 1'b0};
   assign press_here      = cab_btn[Actual_Stage] | up_btn_by_floor[Actual_Stage] |
                            dn_btn_by_floor[Actual_Stage];

   // Target search and stop decision.
   always_comb begin
      above_found = 1'b0;
      above_floor = '0;
      below_found = 1'b0;
      below_floor = '0;
      // Scan downward so the lowest floor above the car is kept last.
      for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
         if (pending_w[f] && (f > int'(Actual_Stage))) begin
            above_found = 1'b1;
            above_floor = floor_t'(f);
         end
      end
      // Scan upward so the highest floor below the car is kept last.
      for (int f = 0; f < NUM_FLOORS; f++) begin
         if (pending_w[f] && (f < int'(Actual_Stage))) begin
            below_found = 1'b1;
            below_floor = floor_t'(f);
         end
      end

      hall_here = up_by_floor[Actual_Stage] | dn_by_floor[Actual_Stage];
      stop_here = cab_call[Actual_Stage];
      tgt_valid = 1'b0;
      tgt_floor = '0;
      case (UD_Answer)
         UP: begin
            // A hall call against the travel direction is taken only when the car has nothing further up.
            stop_here = stop_here | up_by_floor[Actual_Stage] | (hall_here & ~above_found);
            if (above_found) begin
               tgt_valid = 1'b1;
               tgt_floor = above_floor;
            end else if (below_found) begin
               tgt_valid = 1'b1;
               tgt_floor = below_floor;
            end
         end
         DOWN: begin
            stop_here = stop_here | dn_by_floor[Actual_Stage] | (hall_here & ~below_found);
            if (below_found) begin
               tgt_valid = 1'b1;
               tgt_floor = below_floor;
            end else if (above_found) begin
               tgt_valid = 1'b1;
               tgt_floor = above_floor;
            end
         end
      endcase

      next_stage_d = {tgt_valid, tgt_floor};
      ud_d         = tgt_valid & (tgt_floor > Actual_Stage);
      no_stop_d    = STOP & (|pending_w) & ~OC_Request;
   end

   // FSM next-state and control.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fr_ack_d  = 1'b0;
      clear_at  = 1'b0;
      absorb_at = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (Delay) begin
               state_d = ST_EVAL;
            end else if (FR_Delay) begin
               state_d = ST_FRSVC;
            end
         end
         ST_EVAL: begin
            if (stop_here) begin
               clear_at = 1'b1;
               cnt_d    = CNT_W'(DOOR_HOLD);
               state_d  = ST_DOOR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DOOR: begin
            absorb_at = 1'b1;
            // Guard on the previous ack keeps a still-high poll from a second pulse.
            fr_ack_d  = FR_Delay & ~fr_ack_q;
            if (press_here) begin
               cnt_d = CNT_W'(DOOR_HOLD);
            end else if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_FRSVC: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         fr_ack_q     <= 1'b0;
         next_stage_q <= 3'b000;
         ud_q         <= 1'b0;
         no_stop_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fr_ack_q     <= fr_ack_d;
         next_stage_q <= next_stage_d;
         ud_q         <= ud_d;
         no_stop_q    <= no_stop_d;
      end
   end

   // Decoded straight from the state register, so reset drops the door request at once.
   assign OC_Request  = (state_q == ST_DOOR);
   assign DoneDelay   = (state_q == ST_EVAL);
   assign DoneFRDelay = (state_q == ST_FRSVC) | fr_ack_q;
   assign next_stage  = next_stage_q;
   assign UD_Request  = ud_q;
   assign NO_STOP     = no_stop_q;
   assign pending     = pending_w;

endmodule

// File: tb/tb_request_controller.sv
module tb_request_controller;

   localparam int HOLD = 8;

   localparam int M_PLAIN     = 0;
   localparam int M_EVALPRESS = 1;
   localparam int M_ABSORB    = 2;
   localparam int M_FRDOOR    = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cab_btn;
   logic [2:0] hall_up, hall_dn;
   logic       Delay, FR_Delay;
   logic [1:0] Actual_Stage;
   logic       UD_Answer, STOP;
   logic [2:0] next_stage;
   logic       OC_Request, UD_Request, NO_STOP, DoneDelay, DoneFRDelay;
   logic [3:0] pending;

   always #5 clk = ~clk;

   request_controller #(
      .DOOR_HOLD (HOLD),
      .NUM_FLOORS(4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cab_btn     (cab_btn),
      .hall_up     (hall_up),
      .hall_dn     (hall_dn),
      .Delay       (Delay),
      .FR_Delay    (FR_Delay),
      .Actual_Stage(Actual_Stage),
      .UD_Answer   (UD_Answer),
      .STOP        (STOP),
      .next_stage  (next_stage),
      .OC_Request  (OC_Request),
      .UD_Request  (UD_Request),
      .NO_STOP     (NO_STOP),
      .DoneDelay   (DoneDelay),
      .DoneFRDelay (DoneFRDelay),
      .pending     (pending)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model: calls kept per floor ----------------
   bit m_cab[4];
   bit m_up[4];
   bit m_dn[4];

   function automatic bit m_pend(int f);
      return m_cab[f] | m_up[f] | m_dn[f];
   endfunction

   function automatic int m_pend_mask();
      int r = 0;
      for (int f = 0; f < 4; f++) if (m_pend(f)) r |= (1 << f);
      return r;
   endfunction

   function automatic int m_target(int s, bit dir);
      int step = dir ? 1 : -1;
      for (int d = 1; d < 4; d++) begin
         int f = s + step * d;
         if (f >= 0 && f < 4 && m_pend(f)) return f;
      end
      for (int d = 1; d < 4; d++) begin
         int f = s - step * d;
         if (f >= 0 && f < 4 && m_pend(f)) return f;
      end
      return -1;
   endfunction

   function automatic bit m_beyond(int s, bit dir);
      for (int f = 0; f < 4; f++) if (m_pend(f) && (dir ? (f > s) : (f < s))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_stop(int s, bit dir);
      return m_cab[s] | (dir ? m_up[s] : m_dn[s]) | ((m_up[s] | m_dn[s]) & !m_beyond(s, dir));
   endfunction

   function automatic void m_clear(int s);
      m_cab[s] = 0;
      m_up[s]  = 0;
      m_dn[s]  = 0;
   endfunction

   function automatic void m_press(logic [3:0] c, logic [2:0] u, logic [2:0] d);
      for (int f = 0; f < 4; f++) if (c[f]) m_cab[f] = 1;
      for (int n = 0; n < 3; n++) begin
         if (u[n]) m_up[n] = 1;
         if (d[n]) m_dn[n+1] = 1;
      end
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      bit is_fr;
      bit stop;
      int door_len;
      int nxt;
      bit ud;
      int pend;
      bit nostop;
   } exp_t;

   exp_t sb[$];
   exp_t me;
   int   dd_run = 0, fr_run = 0, oc_run = 0;
   int   door_len_arm = 0, door_len_cur = 0;
   bit   door_armed = 0;

   always @(negedge clk) begin
      if (reset) begin
         dd_run = 0; fr_run = 0; oc_run = 0; door_armed = 0;
      end else begin
         if (DoneDelay) begin
            if (dd_run == 0) begin
               if (sb.size() == 0) check("dd_unexpected", 1, 0);
               else begin
                  me = sb.pop_front();
                  check("dd_order", me.is_fr, 0);
                  door_armed   = me.stop;
                  door_len_arm = me.door_len;
               end
            end
            dd_run++;
         end else begin
            if (dd_run != 0) check("dd_width", dd_run, 1);
            dd_run = 0;
         end

         if (DoneFRDelay) begin
            if (fr_run == 0) begin
               if (sb.size() == 0) check("fr_unexpected", 1, 0);
               else begin
                  me = sb.pop_front();
                  check("fr_order", me.is_fr, 1);
                  check("next_stage", next_stage, me.nxt);
                  check("ud_request", UD_Request, me.ud);
                  check("pending", pending, me.pend);
                  check("no_stop", NO_STOP, me.nostop);
               end
            end
            fr_run++;
         end else begin
            if (fr_run != 0) check("fr_width", fr_run, 1);
            fr_run = 0;
         end

         if (OC_Request) begin
            if (oc_run == 0) begin
               check("door_expected", door_armed, 1);
               door_len_cur = door_len_arm;
               door_armed   = 0;
            end
            oc_run++;
         end else begin
            if (oc_run != 0) check("door_len", oc_run, door_len_cur);
            oc_run = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(logic [3:0] c, logic [2:0] u, logic [2:0] d);
      cab_btn = c; hall_up = u; hall_dn = d;
      m_press(c, u, d);
      tick(1);
      cab_btn = '0; hall_up = '0; hall_dn = '0;
   endtask

   task automatic setup(int s, bit dir);
      Actual_Stage = 2'(s);
      UD_Answer    = dir;
      tick(2);
   endtask

   // Car side: drop each request once its acknowledge is seen.
   task automatic wait_ack();
      int n = 0;
      while ((Delay || FR_Delay) && n < 20) begin
         tick(1);
         if (DoneDelay) Delay = 0;
         if (DoneFRDelay) FR_Delay = 0;
         n++;
      end
      if (Delay || FR_Delay) begin
         check("ack_timeout", 0, 1);
         Delay = 0; FR_Delay = 0;
      end
   endtask

   task automatic push_fr(bit in_door);
      exp_t e;
      int t = m_target(int'(Actual_Stage), UD_Answer);
      e.is_fr    = 1;
      e.stop     = 0;
      e.door_len = 0;
      e.nxt      = (t < 0) ? 0 : 4 + t;
      e.ud       = (t > int'(Actual_Stage));
      e.pend     = m_pend_mask();
      e.nostop   = !in_door && STOP && (e.pend != 0);
      sb.push_back(e);
   endtask

   task automatic push_arrive(bit stp, int len);
      exp_t e;
      e.is_fr = 0; e.stop = stp; e.door_len = len;
      e.nxt = 0; e.ud = 0; e.pend = 0; e.nostop = 0;
      sb.push_back(e);
   endtask

   task automatic fr_poll(int s, bit dir);
      setup(s, dir);
      push_fr(0);
      FR_Delay = 1;
      wait_ack();
      tick(1);
   endtask

   task automatic arrival(int s, bit dir, int mode);
      bit stp;
      int n = 0;
      setup(s, dir);
      stp = m_stop(s, dir);
      push_arrive(stp, (mode == M_ABSORB) ? 6 + HOLD : HOLD);
      if (stp) m_clear(s);
      Delay = 1;
      wait_ack();
      // now in the acknowledge cycle
      if (mode == M_EVALPRESS) begin
         cab_btn = 4'b0001;      // elsewhere: kept
         hall_up = 3'b010;       // at the car (floor 1): lost to the clear
         m_press(4'b0001, 3'b000, 3'b000);
      end
      tick(1);
      cab_btn = '0; hall_up = '0;
      if (stp) begin
         check("door_open", OC_Request, 1);
         if (mode == M_ABSORB) begin
            tick(5);
            cab_btn = 4'(1 << s);
            tick(1);
            cab_btn = '0;
         end
         if (mode == M_FRDOOR) begin
            push_fr(1);
            FR_Delay = 1;
            wait_ack();
         end
      end
      while (OC_Request && n < 40) begin
         tick(1);
         n++;
      end
      if (OC_Request) check("door_timeout", 0, 1);
      tick(1);
   endtask

   task automatic both_requests(int s, bit dir);
      setup(s, dir);
      push_arrive(m_stop(s, dir), HOLD);
      push_fr(0);
      Delay = 1;
      FR_Delay = 1;
      wait_ack();
      tick(2);
   endtask

   initial begin
      int  s;
      bit  dir;
      logic [3:0] c;
      logic [2:0] u, d;

      reset = 1; cab_btn = 0; hall_up = 0; hall_dn = 0;
      Delay = 0; FR_Delay = 0; Actual_Stage = 0; UD_Answer = 1; STOP = 0;
      tick(2);
      check("rst_next_stage", next_stage, 0);
      check("rst_oc", OC_Request, 0);
      check("rst_ud", UD_Request, 0);
      check("rst_no_stop", NO_STOP, 0);
      check("rst_done", {DoneDelay, DoneFRDelay}, 0);
      check("rst_pending", pending, 0);
      reset = 0;
      tick(1);

      // idle car, call to top floor
      STOP = 1;
      press(4'b1000, 3'b000, 3'b000);
      fr_poll(0, 1);
      STOP = 0;

      // up hall call at floor 1 with same-cycle presses during the clear
      press(4'b0000, 3'b010, 3'b000);
      arrival(1, 1, M_EVALPRESS);
      fr_poll(1, 1);

      // clear remaining work, then a lone down call at floor 1 heading up
      arrival(3, 1, M_PLAIN);
      arrival(0, 0, M_PLAIN);
      press(4'b0000, 3'b000, 3'b001);
      arrival(1, 1, M_PLAIN);

      // target beyond the car in travel direction
      press(4'b1001, 3'b000, 3'b000);
      fr_poll(2, 1);

      // press at the car with the door open restarts the hold
      arrival(3, 1, M_ABSORB);

      // poll answered while the door stays open
      press(4'b0000, 3'b100, 3'b000);
      arrival(0, 0, M_FRDOOR);

      // both requests at once, nothing to stop for at floor 1
      STOP = 1;
      both_requests(1, 0);
      STOP = 0;

      for (int i = 0; i < 40; i++) begin
         s    = $urandom_range(0, 3);
         dir  = 1'($urandom_range(0, 1));
         STOP = 1'($urandom_range(0, 1));
         c = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         u = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
         d = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
         press(c, u, d);
         if ($urandom_range(0, 1) == 1) arrival(s, dir, M_PLAIN);
         else fr_poll(s, dir);
      end

      // reset while the door is open
      press(4'b0010, 3'b000, 3'b000);
      setup(1, 1);
      push_arrive(1, HOLD);
      m_clear(1);
      Delay = 1;
      wait_ack();
      tick(3);
      #2;
      reset = 1;
      #1;
      check("reset_door_oc", OC_Request, 0);
      check("reset_pending", pending, 0);
      check("reset_next_stage", next_stage, 0);
      for (int f = 0; f < 4; f++) m_clear(f);
      tick(2);
      reset = 0;
      tick(2);
      check("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/request_controller.md
REQUEST_CONTROLLER -- requirements
Module: request_controller

Interface
REQ-001 Parameter DOOR_HOLD, default 8: clocks OC_Request stays high per door-open service.
REQ-002 Parameter NUM_FLOORS, default 4: floors served, indices 0..3.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cab_btn  in  4  car-panel call pulses, bit n = floor n.
REQ-006 hall_up  in  3  up hall call pulses, bit n = floor n (floors 0..2).
REQ-007 hall_dn  in  3  down hall call pulses, bit n = floor n+1 (floors 1..3).
REQ-008 Delay  in  1  car FSM arrival notice; level held until DoneDelay.
REQ-009 FR_Delay  in  1  car FSM floor-request poll; level held until DoneFRDelay.
REQ-010 Actual_Stage  in  2  car's current floor.
REQ-011 UD_Answer  in  1  car direction, 1 = up, 0 = down.
REQ-012 STOP  in  1  car idle flag.
REQ-013 next_stage  out  3  bit2 = target valid, bits[1:0] = target floor; 3'b000 = none.
REQ-014 OC_Request  out  1  door-open request to car FSM.
REQ-015 UD_Request  out  1  1 = target above Actual_Stage.
REQ-016 NO_STOP  out  1  wake request to idle car.
REQ-017 DoneDelay  out  1  one-clock pulse acknowledging Delay.
REQ-018 DoneFRDelay  out  1  one-clock pulse acknowledging FR_Delay.
REQ-019 pending  out  4  OR of all latched calls per floor (lamp drive).

Function
REQ-020 Call bits set on any cycle their button is 1; held until serviced.
REQ-021 States: IDLE, EVAL, DOOR, FRSVC.
REQ-022 IDLE: Delay=1 -> EVAL; else FR_Delay=1 -> FRSVC; Delay wins when both high.
REQ-023 EVAL (1 clock): stop = cab[Actual_Stage] | hall call at Actual_Stage in UD_Answer direction | any hall call at Actual_Stage when no call lies beyond it in UD_Answer direction.
REQ-024 EVAL: DoneDelay pulses; stop=1 clears every call at Actual_Stage and -> DOOR; stop=0 -> IDLE.
REQ-025 DOOR: OC_Request=1 for DOOR_HOLD clocks via down-counter, then -> IDLE with OC_Request=0.
REQ-026 DOOR: press at Actual_Stage is absorbed (not latched) and reloads counter to DOOR_HOLD.
REQ-027 DOOR: FR_Delay=1 is answered in place (DoneFRDelay pulse, next_stage updated) without leaving DOOR.
REQ-028 FRSVC (1 clock): DoneFRDelay pulses, returns IDLE.
REQ-029 Target: nearest pending floor strictly beyond Actual_Stage in UD_Answer direction; else nearest in opposite direction; else none.
REQ-030 next_stage and UD_Request are registered, recomputed every clock; UD_Request=0 when no target.
REQ-031 NO_STOP = registered (STOP & |pending & ~OC_Request).
REQ-032 Call at Actual_Stage while STOP=1 and not DOOR: latched, raises NO_STOP; FSM reports arrival via Delay.
REQ-033 Same-cycle press and clear of one bit: clear wins at Actual_Stage, set wins elsewhere.
REQ-034 Ack pulses never exceed one clock; a request still high on return to IDLE is serviced again.

Reset
REQ-035 Reset clears all calls and counter; state IDLE.
REQ-036 Reset values: next_stage=0, OC_Request=0, UD_Request=0, NO_STOP=0, DoneDelay=0, DoneFRDelay=0, pending=0.
REQ-037 Reset mid-DOOR drops OC_Request on assertion without waiting for a clock.

Structure
REQ-038 Shared package elevator_pkg holds NUM_FLOORS, floor index type, direction constants UP=1/DOWN=0, state enum.
REQ-039 Sub-module call_latch owns the 10 call bits with set/clear/absorb logic; target search stays in top.

Verification
REQ-040 Reset, STOP=1, cab_btn=4'b1000 -> pending=1000, next_stage=3'b111, UD_Request=1, NO_STOP=1 next clock.
REQ-041 Actual_Stage=1, UD_Answer=1, hall_up[1] latched, Delay=1 -> DoneDelay one pulse, call cleared, OC_Request high exactly 8 clocks.
REQ-042 Actual_Stage=1, UD_Answer=1, only hall_dn[0] (floor 1) latched, Delay=1 -> stop, door opens (nothing beyond).
REQ-043 Actual_Stage=2, UD_Answer=1, cab calls floors 0 and 3, FR_Delay=1 -> next_stage=3'b111, DoneFRDelay one pulse.
REQ-044 DOOR with 3 clocks left, cab_btn at Actual_Stage -> not latched, OC_Request lasts 8 more clocks.
REQ-045 Delay and FR_Delay rise same clock -> DoneDelay first; DoneFRDelay only after return to IDLE; reset during DOOR -> OC_Request=0 immediately.
